// File: rtl/hdlc_sca_pkg.sv
// rtl/hdlc_sca_pkg.sv - shared types and constants for the SCA e-link scheduler
package hdlc_sca_pkg;

  localparam logic [2:0] ST_DISC    = 3'd0;
  localparam logic [2:0] ST_SABM    = 3'd1;
  localparam logic [2:0] ST_WAIT_UA = 3'd2;
  localparam logic [2:0] ST_IDLE    = 3'd3;
  localparam logic [2:0] ST_ISSUE   = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  localparam logic TX_KIND_I    = 1'b0;
  localparam logic TX_KIND_SABM = 1'b1;

  typedef logic [2:0] seq_t;

  localparam int DEF_WINDOW      = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/hdlc_rr_arbiter.sv
// rtl/hdlc_rr_arbiter.sv - round-robin requester selection with its own rotating pointer
module hdlc_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             link_clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] jidx;
  int               jj;

  // Scan starting at ptr; the first active requester wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    jj         = 0;
    jidx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      jj   = (int'(ptr) + k) % NREQ;
      jidx = IDX_W'(jj);
      if (!gnt_valid && req[jidx]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = jidx;
        gnt_onehot[jidx] = 1'b1;
      end
    end
  end

  always_ff @(posedge link_clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && gnt_valid) begin
      ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hdlc_sca_scheduler.sv
// rtl/hdlc_sca_scheduler.sv - link bring-up, I-frame issue and retire for one GBT-SCA e-link
module hdlc_sca_scheduler
  import hdlc_sca_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int CMD_W       = 32,
  parameter int WINDOW      = DEF_WINDOW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = 13
) (
  input  logic              link_clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic              tx_kind,
  output logic [CMD_W-1:0]  tx_cmd,
  output logic [2:0]        tx_ns,
  input  logic              tx_busy,
  input  logic              rx_frame_done,
  input  logic              rx_crc_valid,
  output logic              link_up,
  output logic [2:0]        outstanding,
  output logic              timeout_err,
  output logic [7:0]        crc_err_cnt,
  output logic              spurious
);

  localparam int              IDX_W   = $clog2(NREQ);
  localparam logic [2:0]      WIN     = 3'(WINDOW);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state;
  seq_t             ns;
  logic [TO_W-1:0]  to_cnt;
  logic             busy_seen;
  logic             wt_cnt;
  logic [NREQ-1:0]  win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [CMD_W-1:0] win_cmd;
  logic             issue, rx_ok, rx_bad, retire, to_run, to_fire;

  hdlc_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .link_clk   (link_clk),
    .reset      (reset),
    .req        (req),
    .advance    (issue),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx),
    .gnt_valid  (win_valid)
  );

  always_comb begin
    win_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == win_idx) win_cmd = req_cmd[i*CMD_W +: CMD_W];
    end
  end

  assign issue   = (state == ST_ISSUE) && win_valid;
  assign rx_ok   = rx_frame_done && rx_crc_valid;
  assign rx_bad  = rx_frame_done && !rx_crc_valid;
  assign retire  = rx_ok && link_up && (outstanding != 3'd0);
  assign to_run  = (outstanding != 3'd0) || (state == ST_WAIT_UA);
  // A reply or an issue landing on the last cycle reloads instead of expiring.
  assign to_fire = to_run && !issue && !rx_ok && (to_cnt == TO_LAST);

  always_ff @(posedge link_clk) begin
    if (reset) begin
      state       <= ST_DISC;
      ns          <= '0;
      link_up     <= 1'b0;
      outstanding <= 3'd0;
      timeout_err <= 1'b0;
      crc_err_cnt <= 8'd0;
      spurious    <= 1'b0;
      to_cnt      <= '0;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_kind     <= TX_KIND_I;
      tx_cmd      <= '0;
      tx_ns       <= 3'd0;
      busy_seen   <= 1'b0;
      wt_cnt      <= 1'b0;
    end else begin
      grant    <= '0;
      tx_start <= 1'b0;

      if (rx_bad && crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;
      if (rx_ok && link_up && outstanding == 3'd0) spurious <= 1'b1;

      if (issue && !retire)      outstanding <= outstanding + 3'd1;
      else if (!issue && retire) outstanding <= outstanding - 3'd1;

      if (issue || rx_ok || to_fire || !to_run) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + 1'b1;

      case (state)
        ST_DISC: state <= ST_SABM;
        ST_SABM: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_kind  <= TX_KIND_SABM;
            state    <= ST_WAIT_UA;
          end
        end
        ST_WAIT_UA: begin
          if (rx_ok) begin
            link_up <= 1'b1;
            ns      <= '0;
            state   <= ST_IDLE;
          end else if (to_fire) begin
            state <= ST_DISC;
          end
        end
        ST_IDLE: begin
          if ((|req) && outstanding < WIN && !tx_busy) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          busy_seen <= 1'b0;
          wt_cnt    <= 1'b0;
          if (win_valid) begin
            grant    <= win_onehot;
            tx_start <= 1'b1;
            tx_kind  <= TX_KIND_I;
            tx_cmd   <= win_cmd;
            tx_ns    <= ns;
            ns       <= ns + 3'd1;
            state    <= ST_WAIT_TX;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_TX: begin
          // Busy that never rises within two cycles counts as a completed frame.
          if (tx_busy)                 busy_seen <= 1'b1;
          else if (busy_seen || wt_cnt) state    <= ST_IDLE;
          else                          wt_cnt   <= 1'b1;
        end
        default: state <= ST_DISC;
      endcase

      if (to_fire && outstanding != 3'd0) begin
        timeout_err <= 1'b1;
        outstanding <= 3'd0;
        link_up     <= 1'b0;
        state       <= ST_DISC;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_sca_scheduler.sv
// tb/tb_hdlc_sca_scheduler.sv - directed self-checking bench for hdlc_sca_scheduler
module tb_hdlc_sca_scheduler;

  localparam int NREQ  = 4;
  localparam int CMD_W = 32;

  logic                  link_clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*CMD_W-1:0] req_cmd;
  logic [NREQ-1:0]       grant;
  logic                  tx_start;
  logic                  tx_kind;
  logic [CMD_W-1:0]      tx_cmd;
  logic [2:0]            tx_ns;
  logic                  tx_busy;
  logic                  rx_frame_done;
  logic                  rx_crc_valid;
  logic                  link_up;
  logic [2:0]            outstanding;
  logic                  timeout_err;
  logic [7:0]            crc_err_cnt;
  logic                  spurious;

  int n_vec = 0;
  int n_err = 0;
  int sabm_cnt = 0;
  int ifr_cnt = 0;
  int grant_cnt = 0;

  hdlc_sca_scheduler #(
    .NREQ(NREQ), .CMD_W(CMD_W), .WINDOW(4), .TIMEOUT_CYC(64), .TO_W(7)
  ) dut (
    .link_clk      (link_clk),
    .reset         (reset),
    .req           (req),
    .req_cmd       (req_cmd),
    .grant         (grant),
    .tx_start      (tx_start),
    .tx_kind       (tx_kind),
    .tx_cmd        (tx_cmd),
    .tx_ns         (tx_ns),
    .tx_busy       (tx_busy),
    .rx_frame_done (rx_frame_done),
    .rx_crc_valid  (rx_crc_valid),
    .link_up       (link_up),
    .outstanding   (outstanding),
    .timeout_err   (timeout_err),
    .crc_err_cnt   (crc_err_cnt),
    .spurious      (spurious)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  always @(negedge link_clk) begin
    if (!reset) begin
      if (tx_start && tx_kind)  sabm_cnt++;
      if (tx_start && !tx_kind) ifr_cnt++;
      if (grant != '0)          grant_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {9'd0, grant, tx_start, tx_kind, tx_cmd, tx_ns, link_up, outstanding,
            timeout_err, crc_err_cnt, spurious};
  endfunction

  function automatic logic [31:0] cmd_of(input int i);
    return 32'(32'hC0DE_0000 + i);
  endfunction

  task automatic step();
    @(posedge link_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tx_busy = 1'b0;
    rx_frame_done = 1'b0;
    rx_crc_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    sabm_cnt = 0;
    ifr_cnt = 0;
    grant_cnt = 0;
  endtask

  task automatic send_rx(input logic crc);
    rx_frame_done = 1'b1;
    rx_crc_valid = crc;
    step();
    rx_frame_done = 1'b0;
    rx_crc_valid = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant == '0 && n < 40) begin
      step();
      n++;
    end
    check(tag, 64'(grant != '0), 64'd1);
  endtask

  task automatic wait_sabm(input string tag);
    int n = 0;
    while (!(tx_start && tx_kind) && n < 40) begin
      step();
      n++;
    end
    check(tag, 64'(tx_start && tx_kind), 64'd1);
  endtask

  task automatic connect();
    do_reset();
    wait_sabm("sabm_seen");
    send_rx(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) req_cmd[i*CMD_W +: CMD_W] = cmd_of(i);

    // Reset state and connect with a busy transmitter
    do_reset();
    reset = 1'b1;
    step();
    check("reset_outputs", out_vec(), 64'd0);
    reset = 1'b0;
    tx_busy = 1'b1;
    req = 4'b0001;
    repeat (10) step();
    check("sabm_held_by_busy", 64'(sabm_cnt), 64'd0);
    tx_busy = 1'b0;
    wait_sabm("sabm_after_busy");
    repeat (3) step();
    check("no_grant_link_down", 64'(grant_cnt), 64'd0);
    send_rx(1'b1);
    req = '0;
    check("connect_link_up", 64'(link_up), 64'd1);
    check("connect_outstanding", 64'(outstanding), 64'd0);
    check("connect_one_sabm", 64'(sabm_cnt), 64'd1);

    // Fairness with instant replies
    connect();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("fair_wait");
      check($sformatf("fair_grant%0d", k), 64'(grant), 64'(4'b0001 << (k % 4)));
      check($sformatf("fair_ns%0d", k), 64'(tx_ns), 64'(k));
      check($sformatf("fair_cmd%0d", k), 64'(tx_cmd), 64'(cmd_of(k % 4)));
      if (k == 4) req = '0;
      send_rx(1'b1);
      check($sformatf("fair_retire%0d", k), 64'(outstanding), 64'd0);
    end
    repeat (5) step();
    check("fair_iframes", 64'(ifr_cnt), 64'd5);
    check("fair_grants", 64'(grant_cnt), 64'd5);

    // Window fills at 4, a reply frees one slot
    connect();
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      wait_grant("win_wait");
      check($sformatf("win_grant%0d", k), 64'(grant), 64'(4'b0100));
      check($sformatf("win_ns%0d", k), 64'(tx_ns), 64'(k));
      step();
    end
    repeat (20) step();
    check("win_full_outstanding", 64'(outstanding), 64'd4);
    check("win_full_no_grant", 64'(grant_cnt), 64'd4);
    send_rx(1'b1);
    check("win_after_reply", 64'(outstanding), 64'd3);
    wait_grant("win_wait5");
    check("win_ns5", 64'(tx_ns), 64'd4);
    check("win_refill", 64'(outstanding), 64'd4);
    req = '0;

    // Issue and retire together, then a bad CRC
    connect();
    req = 4'b0001;
    wait_grant("sim_wait0");
    req = '0;
    step();
    req = 4'b0010;
    wait_grant("sim_wait1");
    req = '0;
    check("sim_two_out", 64'(outstanding), 64'd2);
    repeat (5) step();
    req = 4'b1000;
    step();
    rx_frame_done = 1'b1;
    rx_crc_valid = 1'b1;
    step();
    rx_frame_done = 1'b0;
    rx_crc_valid = 1'b0;
    req = '0;
    check("sim_grant_latency", 64'(grant), 64'(4'b1000));
    check("sim_outstanding", 64'(outstanding), 64'd2);
    send_rx(1'b0);
    check("badcrc_count", 64'(crc_err_cnt), 64'd1);
    check("badcrc_outstanding", 64'(outstanding), 64'd2);

    // Reply timeout, reconnect, spurious reply
    connect();
    req = 4'b0001;
    wait_grant("to_wait");
    req = '0;
    repeat (63) step();
    check("to_not_yet", 64'(timeout_err), 64'd0);
    step();
    check("to_err", 64'(timeout_err), 64'd1);
    check("to_link_down", 64'(link_up), 64'd0);
    check("to_outstanding", 64'(outstanding), 64'd0);
    wait_sabm("to_resabm");
    send_rx(1'b1);
    check("to_relink", 64'(link_up), 64'd1);
    send_rx(1'b1);
    check("spurious_set", 64'(spurious), 64'd1);
    check("spurious_outstanding", 64'(outstanding), 64'd0);
    check("to_err_sticky", 64'(timeout_err), 64'd1);

    // Reset in the middle of a frame with three outstanding
    connect();
    req = 4'b0010;
    wait_grant("rst_wait0");
    step();
    wait_grant("rst_wait1");
    step();
    wait_grant("rst_wait2");
    req = '0;
    check("rst_pre_outstanding", 64'(outstanding), 64'd3);
    tx_busy = 1'b1;
    reset = 1'b1;
    step();
    check("rst_mid_outputs", out_vec(), 64'd0);
    reset = 1'b0;
    tx_busy = 1'b0;
    begin
      int n = 0;
      while (!tx_start && n < 40) begin
        step();
        n++;
      end
      check("rst_next_start", 64'(tx_start), 64'd1);
      check("rst_next_is_sabm", 64'(tx_kind), 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
